uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Transmit-side controller for the UART. It sits directly upstream of the TX output-select stage and produces that stage's 3-bit select plus its four bit sources: start, serial data, parity and stop. It accepts a parallel byte over a valid/ready handshake and sequences the frame in this order: start, data LSB-first, optional parity, stop. Each bit lasts CLKS_PER_BIT clocks.

Parameters:
DATA_WIDTH, 8, data bits per frame (legal 5..9)
CLKS_PER_BIT, 16, clock cycles per bit period (legal >= 2)
PARITY_EN, 1, 1 = insert parity bit, 0 = no parity state
PARITY_ODD, 0, 0 = even parity, 1 = odd parity

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
tx_valid  input  1  upstream has a byte to send
tx_data  input  DATA_WIDTH  byte to send, sampled on handshake
tx_ready  output  1  controller can accept a byte (IDLE only)
busy  output  1  frame in progress
mux_sel  output  3  bit select: 0 idle, 1 start, 2 data, 3 parity, 4 stop
start_bit  output  1  constant 0
ser_data  output  1  current data bit (shift register LSB)
parity_bit  output  1  parity of captured byte
stop_bit  output  1  constant 1

Behaviour:
- Clock/reset: one clock (clk); reset (rst) is asynchronous and active-low. Reset values: state IDLE, mux_sel 0, tx_ready 1, busy 0, ser_data 0, parity_bit 0. Internal counters and shift register clear to 0.
- Reset mid-frame aborts the frame immediately; no partial bit completes. After rst is released, the next frame starts clean.
- States: IDLE, START, DATA, PARITY, STOP. mux_sel is registered and equals the state code (IDLE=0 … STOP=4). busy = (state != IDLE).
- Handshake: tx_ready = (state == IDLE). On the clock where tx_valid && tx_ready:
  - tx_data is captured into the shift register;
  - parity_bit is registered as (^tx_data) ^ PARITY_ODD;
  - the next state is START.
- While busy, tx_valid is ignored and tx_data is not sampled. Changes to tx_data after the handshake do not affect the frame.
- Baud counter: resets to 0 on every state entry and counts 0..CLKS_PER_BIT-1. bit_done is asserted at count CLKS_PER_BIT-1. Every non-IDLE state therefore lasts exactly CLKS_PER_BIT cycles per bit.
- START: on bit_done, go to DATA with bit index 0.
- DATA: ser_data = shift_reg[0]. On bit_done:
  - shift right and increment the bit index;
  - at index DATA_WIDTH-1, go to PARITY if PARITY_EN, else go to STOP.
- PARITY: on bit_done, go to STOP.
- STOP: on bit_done, go to IDLE.
- No accept is allowed in STOP, so at least one IDLE cycle separates frames.
- Frame timing, with handshake at edge T:
  - mux_sel becomes 1 at T+1;
  - IDLE is re-entered at T+1+(2+DATA_WIDTH+PARITY_EN)*CLKS_PER_BIT.
- The downstream select stage registers mux_sel, which adds one uniform cycle of line latency. Bit widths on the line are unchanged.

Decomposition:
- Shared header/package uart_defines holds:
  - select codes SEL_IDLE=0, SEL_START=1, SEL_DATA=2, SEL_PARITY=3, SEL_STOP=4, and SEL_W=3;
  - the state encoding.
  The downstream select stage uses the same codes.
- One sub-module, uart_baud_cnt:
  - inputs: clk, rst, clear (pulsed on state entry);
  - output: bit_done;
  - parameterised by CLKS_PER_BIT;
  - reused later by the RX side.

Test Plan:
- Reset: hold rst=0 with tx_valid=1 -> mux_sel=0, tx_ready=1, busy=0. No handshake occurs while reset is asserted.
- Defaults, send 0xA5 with handshake at T -> expected sequence:
  - mux_sel=1 for T+1..T+16;
  - mux_sel=2 for 128 cycles, ser_data bits 1,0,1,0,0,1,0,1 each held 16 cycles;
  - mux_sel=3 with parity_bit=0;
  - mux_sel=4 for 16 cycles;
  - tx_ready=1 again at T+177.
- PARITY_ODD=1, send 0x07 -> parity_bit=0 (even parity would give 1). Frame length is still 176 cycles.
- PARITY_EN=0, send 0xFF -> mux_sel goes 2 to 4 directly with no 3, ser_data=1 for all 8 data bits, and IDLE returns at T+161.
- Busy ignore: during the 0xA5 frame, drive tx_valid=1 with tx_data=0x3C -> the frame bits stay 0xA5. 0x3C is accepted only on the first IDLE cycle after the frame, and that frame carries 0x3C.
- Abort: assert rst during data bit 3 -> mux_sel=0 and tx_ready=1 immediately, without waiting for a clock edge. After release, a new frame with 0x5A starts with a full 16-cycle start bit.

Source files
------------

// File: rtl/uart_defines.sv
// Select codes and state encoding shared by the UART TX controller and the
// downstream TX output-select stage.
package uart_defines;

  localparam int SEL_W = 3;

  localparam logic [SEL_W-1:0] SEL_IDLE   = 3'd0;
  localparam logic [SEL_W-1:0] SEL_START  = 3'd1;
  localparam logic [SEL_W-1:0] SEL_DATA   = 3'd2;
  localparam logic [SEL_W-1:0] SEL_PARITY = 3'd3;
  localparam logic [SEL_W-1:0] SEL_STOP   = 3'd4;

  // State codes equal the select codes so the state register doubles as mux_sel.
  typedef enum logic [SEL_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of a bit.
// A clear pulse restarts the period; shared between the TX and RX sides.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clear || bit_done) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign bit_done = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a byte over valid/ready and sequences
// start, LSB-first data, optional parity and stop for the TX output-select stage.
module uart_tx_ctrl
  import uart_defines::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  busy,
  output logic [SEL_W-1:0]      mux_sel,
  output logic                  start_bit,
  output logic                  ser_data,
  output logic                  parity_bit,
  output logic                  stop_bit
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [IDX_W-1:0]        bit_idx_reg;
  logic                    parity_reg;
  logic                    accept;
  logic                    bit_done;
  logic                    state_entry;

  assign accept      = tx_valid && tx_ready;
  assign state_entry = (state_next != state_reg);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_entry),
    .bit_done(bit_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (accept) state_next = ST_START;
      ST_START:  if (bit_done) state_next = ST_DATA;
      ST_DATA: begin
        if (bit_done && (bit_idx_reg == IDX_LAST)) begin
          state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (bit_done) state_next = ST_STOP;
      ST_STOP:   if (bit_done) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Byte and parity are frozen at the handshake; later tx_data changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      parity_reg  <= 1'b0;
    end else if (accept) begin
      shift_reg   <= tx_data;
      bit_idx_reg <= '0;
      parity_reg  <= (^tx_data) ^ (PARITY_ODD != 0);
    end else if ((state_reg == ST_DATA) && bit_done) begin
      shift_reg   <= shift_reg >> 1;
      bit_idx_reg <= bit_idx_reg + IDX_W'(1);
    end
  end

  assign mux_sel    = state_reg;
  assign tx_ready   = (state_reg == ST_IDLE);
  assign busy       = (state_reg != ST_IDLE);
  assign start_bit  = 1'b0;
  assign stop_bit   = 1'b1;
  assign ser_data   = shift_reg[0];
  assign parity_bit = parity_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: three instances cover default, odd-parity
// and no-parity builds; each bit period is checked cycle by cycle.
module tb_uart_tx_ctrl;

  localparam int CPB = 16;

  localparam int K_START = 0;
  localparam int K_SER   = 1;
  localparam int K_PAR   = 2;
  localparam int K_STOP  = 3;

  logic       clk;
  logic       rst;
  logic       valid [3];
  logic [7:0] data  [3];
  logic       rdy   [3];
  logic       bsy   [3];
  logic [2:0] sel   [3];
  logic       stb   [3];
  logic       ser   [3];
  logic       par   [3];
  logic       spb   [3];

  int pass_cnt;
  int total_cnt;

  uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut_def (
    .clk(clk), .rst(rst), .tx_valid(valid[0]), .tx_data(data[0]), .tx_ready(rdy[0]),
    .busy(bsy[0]), .mux_sel(sel[0]), .start_bit(stb[0]), .ser_data(ser[0]),
    .parity_bit(par[0]), .stop_bit(spb[0])
  );

  uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst(rst), .tx_valid(valid[1]), .tx_data(data[1]), .tx_ready(rdy[1]),
    .busy(bsy[1]), .mux_sel(sel[1]), .start_bit(stb[1]), .ser_data(ser[1]),
    .parity_bit(par[1]), .stop_bit(spb[1])
  );

  uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) dut_np (
    .clk(clk), .rst(rst), .tx_valid(valid[2]), .tx_data(data[2]), .tx_ready(rdy[2]),
    .busy(bsy[2]), .mux_sel(sel[2]), .start_bit(stb[2]), .ser_data(ser[2]),
    .parity_bit(par[2]), .stop_bit(spb[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("check %-18s got %0d expected %0d ok", tag, got, exp);
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Samples one bit period; counts the cycles where select, bit source and busy match.
  task automatic seg(input int u, input logic [2:0] exp_sel, input int kind,
                     input logic exp_val, input string tag);
    int   good;
    logic v;
    good = 0;
    for (int c = 0; c < CPB; c++) begin
      case (kind)
        K_START: v = stb[u];
        K_SER:   v = ser[u];
        K_PAR:   v = par[u];
        default: v = spb[u];
      endcase
      if (sel[u] === exp_sel && v === exp_val && bsy[u] === 1'b1 && rdy[u] === 1'b0) good++;
      step();
    end
    check(tag, good, CPB);
  endtask

  // Handshake on the next edge, then walk the whole frame and the return to IDLE.
  task automatic run_frame(input int u, input logic [7:0] d, input bit has_par,
                           input logic exp_par, input logic hold_v,
                           input logic [7:0] hold_d, input string name);
    check({name, "_rdy_pre"}, {31'd0, rdy[u]}, 32'd1);
    valid[u] = 1'b1;
    data[u]  = d;
    step();
    valid[u] = hold_v;
    data[u]  = hold_d;
    seg(u, 3'd1, K_START, 1'b0, {name, "_start"});
    for (int i = 0; i < 8; i++) begin
      seg(u, 3'd2, K_SER, d[i], $sformatf("%s_d%0d", name, i));
    end
    if (has_par) seg(u, 3'd3, K_PAR, exp_par, {name, "_parity"});
    seg(u, 3'd4, K_STOP, 1'b1, {name, "_stop"});
    check({name, "_idle_sel"}, {29'd0, sel[u]}, 32'd0);
    check({name, "_idle_rdy"}, {31'd0, rdy[u]}, 32'd1);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst = 1'b0;
    for (int u = 0; u < 3; u++) begin
      valid[u] = 1'b1;
      data[u]  = 8'hA5;
    end

    // Reset held with tx_valid high: nothing may start.
    repeat (4) step();
    check("rst_sel", {29'd0, sel[0]}, 32'd0);
    check("rst_rdy", {31'd0, rdy[0]}, 32'd1);
    check("rst_busy", {31'd0, bsy[0]}, 32'd0);
    check("rst_ser", {31'd0, ser[0]}, 32'd0);
    check("rst_par", {31'd0, par[0]}, 32'd0);
    for (int u = 0; u < 3; u++) valid[u] = 1'b0;
    #2;
    rst = 1'b1;
    step();
    check("post_rst_sel", {29'd0, sel[0]}, 32'd0);

    // 0xA5 even parity -> 0
    run_frame(0, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, "a5");
    // odd parity build, 0x07 has three ones -> 0
    run_frame(1, 8'h07, 1'b1, 1'b0, 1'b0, 8'h00, "odd07");
    // no-parity build: DATA goes straight to STOP, frame 160 cycles
    run_frame(2, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, "np_ff");

    // Busy ignore: 0x3C held valid during the 0xA5 frame, accepted on first IDLE cycle
    run_frame(0, 8'hA5, 1'b1, 1'b0, 1'b1, 8'h3C, "busy_a5");
    run_frame(0, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h00, "next_3c");

    // Abort during data bit 3
    valid[0] = 1'b1;
    data[0]  = 8'hA5;
    step();
    valid[0] = 1'b0;
    repeat (CPB + 3 * CPB + 5) step();
    check("pre_abort_sel", {29'd0, sel[0]}, 32'd2);
    rst = 1'b0;
    #1;
    check("abort_sel", {29'd0, sel[0]}, 32'd0);
    check("abort_rdy", {31'd0, rdy[0]}, 32'd1);
    check("abort_busy", {31'd0, bsy[0]}, 32'd0);
    #2;
    rst = 1'b1;
    step();
    run_frame(0, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00, "post_5a");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
